// File: rtl/addbit_pkg.sv
//------------------------------------------------------------------------------
// Module      : addbit_pkg
// Description : Shared width limits for the addbit adder slice.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package addbit_pkg;

    localparam int ADDBIT_W_DEFAULT = 1;
    localparam int ADDBIT_W_MAX     = 64;

    function automatic bit addbit_w_legal(input int w);
        return (w >= 1) && (w <= ADDBIT_W_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addbit_core.sv
//------------------------------------------------------------------------------
// Module      : addbit_core
// Description : Purely combinational W-bit add with carry in/out.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addbit_core #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    // Operands are widened by one bit so the carry lands in the MSB; X/Z on
    // any input flows straight through the add.
    logic [W:0] w_total;

    assign w_total  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign sum      = w_total[W-1:0];
    assign co       = w_total[W];

endmodule

`default_nettype wire

// File: rtl/addbit.sv
//------------------------------------------------------------------------------
// Module      : addbit
// Description : W-bit adder with combinational and registered outputs plus a
//               sticky carry flag.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addbit
    import addbit_pkg::*;
#(
    parameter int W = ADDBIT_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] sum_q,
    output logic         co_q,
    output logic         vld_q,
    output logic         cy_sticky
);

    generate
        if (!addbit_w_legal(W)) begin : g_bad_w
            $error("addbit: W=%0d outside legal range 1..%0d", W, ADDBIT_W_MAX);
        end
    endgenerate

    logic [W-1:0] w_sum;
    logic         w_co;
    logic [W-1:0] r_sum_q;
    logic         r_co_q;
    logic         r_vld_q;
    logic         r_cy_sticky;

    addbit_core #(
        .W   (W)
    ) u_core (
        .a   (a),
        .b   (b),
        .ci  (ci),
        .sum (w_sum),
        .co  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q <= '0;
            r_co_q  <= 1'b0;
            r_vld_q <= 1'b0;
        end else begin
            r_vld_q <= en;
            if (en) begin
                r_sum_q <= w_sum;
                r_co_q  <= w_co;
            end
        end
    end

    // A captured carry takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cy_sticky <= 1'b0;
        end else if (en && w_co) begin
            r_cy_sticky <= 1'b1;
        end else if (clr) begin
            r_cy_sticky <= 1'b0;
        end
    end

    assign sum       = w_sum;
    assign co        = w_co;
    assign sum_q     = r_sum_q;
    assign co_q      = r_co_q;
    assign vld_q     = r_vld_q;
    assign cy_sticky = r_cy_sticky;

endmodule

`default_nettype wire

// File: tb/tb_addbit.sv
//------------------------------------------------------------------------------
// Module      : tb_addbit
// Description : Directed self-checking bench for addbit (W=4 and W=1 chains).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_addbit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic [W-1:0] sum_q;
    logic         co_q;
    logic         vld_q;
    logic         cy_sticky;

    // single-bit instance for exhaustive truth table
    logic [0:0]   s_a, s_b, s_sum, s_sum_q;
    logic         s_ci, s_co, s_co_q, s_vld_q, s_sticky;

    // four single-bit instances in a ripple chain
    logic [3:0]   r1, r2, ch_sum, ch_sum_q, ch_co_q, ch_vld_q, ch_sticky;
    logic [4:0]   ch_c;
    logic         ch_ci;

    int n_checks = 0;
    int n_errors = 0;

    addbit #(.W(W)) u_dut (
        .a(a), .b(b), .ci(ci), .sum(sum), .co(co),
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .sum_q(sum_q), .co_q(co_q), .vld_q(vld_q), .cy_sticky(cy_sticky)
    );

    addbit #(.W(1)) u_bit (
        .a(s_a), .b(s_b), .ci(s_ci), .sum(s_sum), .co(s_co),
        .clk(clk), .rst_n(rst_n), .en(1'b0), .clr(1'b0),
        .sum_q(s_sum_q), .co_q(s_co_q), .vld_q(s_vld_q), .cy_sticky(s_sticky)
    );

    assign ch_c[0] = ch_ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chain
            addbit #(.W(1)) u_stage (
                .a(r1[gi]), .b(r2[gi]), .ci(ch_c[gi]),
                .sum(ch_sum[gi]), .co(ch_c[gi+1]),
                .clk(clk), .rst_n(rst_n), .en(1'b0), .clr(1'b0),
                .sum_q(ch_sum_q[gi]), .co_q(ch_co_q[gi]),
                .vld_q(ch_vld_q[gi]), .cy_sticky(ch_sticky[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tt_sum;
        logic [7:0] tt_co;
        logic [2:0] idx;
        tt_sum = 8'b1001_0110;
        tt_co  = 8'b1110_1000;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        a = 4'd3; b = 4'd4; ci = 1'b0;
        s_a = 1'b0; s_b = 1'b0; s_ci = 1'b0;
        r1 = 4'd0; r2 = 4'd0; ch_ci = 1'b0;
        #2;

        // reset state, combinational path alive during reset
        check("rst_sum_q",  sum_q, 0);
        check("rst_co_q",   co_q, 0);
        check("rst_vld_q",  vld_q, 0);
        check("rst_sticky", cy_sticky, 0);
        check("rst_comb_sum", sum, 7);
        check("rst_comb_co",  co, 0);

        // single-bit truth table, index = {a,b,ci}
        for (int i = 0; i < 8; i++) begin
            idx  = 3'(i);
            s_a  = idx[2];
            s_b  = idx[1];
            s_ci = idx[0];
            #1;
            check("tt_sum", s_sum, tt_sum[i]);
            check("tt_co",  s_co,  tt_co[i]);
        end

        // ripple chain of four single-bit slices
        r1 = 4'd10; r2 = 4'd0; ch_ci = 1'b0; #1;
        check("chain_10", {ch_c[4], ch_sum}, {1'b0, 4'd10});
        r2 = 4'd2; #1;
        check("chain_12", {ch_c[4], ch_sum}, {1'b0, 4'd12});
        ch_ci = 1'b1; #1;
        check("chain_13", {ch_c[4], ch_sum}, {1'b0, 4'b1101});

        // release reset away from the edge
        @(negedge clk);
        rst_n = 1'b1;

        // capture with carry out
        a = 4'd15; b = 4'd1; ci = 1'b0; en = 1'b1; #1;
        check("ovf_comb_sum", sum, 0);
        check("ovf_comb_co",  co, 1);
        tick();
        check("cap_sum_q",  sum_q, 0);
        check("cap_co_q",   co_q, 1);
        check("cap_vld_q",  vld_q, 1);
        check("cap_sticky", cy_sticky, 1);

        // en low: hold, valid drops, sticky stays
        en = 1'b0; a = 4'd3; b = 4'd4;
        tick();
        check("hold_vld_q",  vld_q, 0);
        check("hold_sum_q",  sum_q, 0);
        check("hold_co_q",   co_q, 1);
        check("hold_sticky", cy_sticky, 1);

        // clear without capture
        clr = 1'b1;
        tick();
        check("clr_sticky", cy_sticky, 0);

        // set wins over clear
        a = 4'd15; b = 4'd1; en = 1'b1;
        tick();
        check("setwin_sticky", cy_sticky, 1);

        // clear with capture but no carry
        a = 4'd2; b = 4'd3;
        tick();
        check("clr_nocy_sticky", cy_sticky, 0);
        check("b2b_vld_q_1", vld_q, 1);
        check("b2b_sum_q_1", sum_q, 5);
        clr = 1'b0;

        // back-to-back capture, one-cycle latency
        a = 4'd1; b = 4'd1; ci = 1'b1;
        tick();
        check("b2b_vld_q_2", vld_q, 1);
        check("b2b_sum_q_2", sum_q, 3);
        check("b2b_co_q_2",  co_q, 0);

        // full overflow wrap
        a = 4'd15; b = 4'd15; ci = 1'b1; #1;
        check("wrap_comb", {co, sum}, {1'b1, 4'd15});
        tick();
        check("wrap_reg", {co_q, sum_q}, {1'b1, 4'd15});

        // async reset mid-cycle with sum_q=5, vld_q=1
        a = 4'd2; b = 4'd3; ci = 1'b0;
        tick();
        check("pre_rst_sum_q", sum_q, 5);
        check("pre_rst_vld_q", vld_q, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sum_q",  sum_q, 0);
        check("arst_co_q",   co_q, 0);
        check("arst_vld_q",  vld_q, 0);
        check("arst_sticky", cy_sticky, 0);
        check("arst_comb",   {co, sum}, {1'b0, 4'd5});

        // reset spans an edge: pending capture discarded
        tick();
        check("arst_hold_vld", vld_q, 0);
        check("arst_hold_sum", sum_q, 0);

        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        check("post_rst_vld", vld_q, 0);
        en = 1'b1;
        tick();
        check("post_rst_cap", sum_q, 5);
        check("post_rst_v",   vld_q, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

`default_nettype wire
